// File: rtl/hstl_rx_capture_if.sv
// Pad-side and consumer-side signal bundle for hstl_rx_capture.
// The master modport is the receiver; the slave modport is its environment.
interface hstl_rx_capture_if #(
    parameter int DATA_W = 8
);
    logic              I;
    logic              T;
    logic [DATA_W-1:0] DO;
    logic              DV;
    logic              DR;
    logic              BUSY;
    logic              FERR;
    logic              OVR;
    logic              PERR;

    modport master (input I, T, DR, output DO, DV, BUSY, FERR, OVR, PERR);
    modport slave  (output I, T, DR, input DO, DV, BUSY, FERR, OVR, PERR);
endinterface

// File: rtl/hstl_rx_capture.sv
// Half-duplex single-wire frame receiver: pad synchroniser, turnaround blanking,
// LSB-first deserialiser and one-entry holding register. HSTL_RX_PARITY_EN adds an even-parity bit.
module hstl_rx_capture #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int TURN_CYC     = 4
) (
    input  logic              C,
    input  logic              CLR,
    hstl_rx_capture_if.master bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int BLK_W = 8;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_STOP    = 3'd3;
    localparam logic [2:0] ST_WAIT_HI = 3'd4;
`ifdef HSTL_RX_PARITY_EN
    localparam logic [2:0] ST_PAR     = 3'd5;
`endif

    logic              s1_q, s1_d, s2_q, s2_d;
    logic [BLK_W-1:0]  blank_q, blank_d;
    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] do_q, do_d;
    logic              dv_q, dv_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              en, expire, deliver;
`ifdef HSTL_RX_PARITY_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;
`endif

    always_comb begin
        s1_d = bus.I;
        s2_d = s1_q;

        // T is the local control, so it is used unsynchronised.
        blank_d = blank_q;
        if (!bus.T)
            blank_d = BLK_W'(TURN_CYC);
        else if (blank_q != '0)
            blank_d = blank_q - 1'b1;
        en     = bus.T && (blank_q == '0);
        expire = (cnt_q == '0);

        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
`ifdef HSTL_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif

        if (state_q != ST_IDLE && !en) begin
            // Local side took the line: drop the frame without any report.
            state_d = ST_IDLE;
        end else begin
            cnt_d = expire ? cnt_q : cnt_q - 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (!s2_q && en) begin
                        state_d = ST_START;
                        cnt_d   = CNT_HALF;
                    end
                end
                ST_START: begin
                    if (expire) begin
                        if (!s2_q) begin
                            state_d = ST_DATA;
                            cnt_d   = CNT_FULL;
                            idx_d   = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (expire) begin
                        sh_d  = (sh_q >> 1) | (DATA_W'(s2_q) << (DATA_W - 1));
                        cnt_d = CNT_FULL;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
`ifdef HSTL_RX_PARITY_EN
                            state_d = ST_PAR;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end
                end
`ifdef HSTL_RX_PARITY_EN
                ST_PAR: begin
                    if (expire) begin
                        par_d   = s2_q;
                        cnt_d   = CNT_FULL;
                        state_d = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (expire) begin
                        if (s2_q) begin
                            state_d = ST_IDLE;
`ifdef HSTL_RX_PARITY_EN
                            if ((^sh_q) != par_q) perr_d = 1'b1;
                            else                  deliver = 1'b1;
`else
                            deliver = 1'b1;
`endif
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_WAIT_HI;
                        end
                    end
                end
                ST_WAIT_HI: begin
                    if (s2_q) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        do_d  = do_q;
        dv_d  = dv_q;
        ovr_d = 1'b0;
        if (dv_q && bus.DR) dv_d = 1'b0;
        if (deliver) begin
            if (!dv_q || bus.DR) begin
                do_d = sh_q;
                dv_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            blank_q <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            do_q    <= '0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef HSTL_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            blank_q <= blank_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            do_q    <= do_d;
            dv_q    <= dv_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef HSTL_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.DO   = do_q;
    assign bus.DV   = dv_q;
    assign bus.BUSY = (state_q != ST_IDLE);
    assign bus.FERR = ferr_q;
    assign bus.OVR  = ovr_q;
`ifdef HSTL_RX_PARITY_EN
    assign bus.PERR = perr_q;
`else
    assign bus.PERR = 1'b0;
`endif
endmodule
